// File: rtl/program_loader_ctrl.sv
// -----------------------------------------------------------------------------
// program_loader_ctrl
//
// Boot / program-load sequencer sitting in front of cpu_16bit. A stream of
// 16-bit instruction words arrives over a valid/ready handshake. Each accepted
// word is written into the CPU instruction memory one cycle later. The CPU is
// held in reset (pc_reset_o=1) until the image is complete. It is then
// released to run from address 0.
//
// Handshake: a word transfers on a rising edge where word_valid_i and
// word_ready_o are both 1. word_ready_o is 1 only while in LOAD. word_valid_i
// may be raised or dropped freely; nothing is accepted while word_ready_o=0.
//
// Optional build macro: LOADER_CHECKSUM_EN. When it is defined:
//   - The word_last word is a 16-bit modulo-2^16 checksum of all written words.
//   - The checksum word itself is not written.
//   - A mismatch sends the block to ERROR instead of HOLD.
//
// Parameters
//   ADDR_W     : width of load_address_o / word_count_o
//   MEM_DEPTH  : instruction words held by the CPU memory (<= 2^ADDR_W)
//   RESET_HOLD : cycles pc_reset_o stays high from the last write (1..255)
//
// Ports
//   clk_i              : clock, rising edge
//   reset_i            : synchronous active-high reset, returns to IDLE
//   start_i            : pulse, begins a new load (IDLE, RUN, ERROR only)
//   word_in_i          : instruction word
//   word_valid_i       : word_in_i valid
//   word_last_i        : word_in_i is the final word of the image
//   word_ready_o       : block accepts a word this cycle
//   instruction_in_o   : CPU write data
//   load_address_o     : CPU write address
//   load_instruction_o : CPU write enable, one cycle per accepted word
//   pc_reset_o         : holds the CPU in reset
//   busy_o             : high in LOAD or HOLD
//   done_o             : high in RUN
//   error_o            : high in ERROR
//   word_count_o       : words written in the current / last load
//   state_o            : current FSM state (debug)
// -----------------------------------------------------------------------------
module program_loader_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [15:0]       word_in_i,
    input  logic              word_valid_i,
    input  logic              word_last_i,
    output logic              word_ready_o,
    output logic [15:0]       instruction_in_o,
    output logic [ADDR_W-1:0] load_address_o,
    output logic              load_instruction_o,
    output logic              pc_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] word_count_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HOLD  = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // The count needs one extra bit so that MEM_DEPTH == 2^ADDR_W can be
    // represented when the memory is completely filled.
    localparam int unsigned   CW      = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);
    localparam logic [7:0]    HOLD_C  = 8'(RESET_HOLD);

    state_t            state_q, state_d;

    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        hold_q, hold_d;

    logic              word_ready_q, word_ready_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_q, load_d;
    logic              pc_reset_q, pc_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
`endif

    logic              xfer;
    logic              full;
    logic              do_write;
    logic              entering_load;
    logic              entering_hold;

    // word_ready_q is only ever 1 in LOAD, so it also qualifies the state.
    assign xfer = word_valid_i & word_ready_q;
    assign full = (count_q == DEPTH_C);

`ifdef LOADER_CHECKSUM_EN
    // The checksum word is never written, so it is legal even when full.
    assign do_write = xfer & ~full & ~word_last_i;
`else
    assign do_write = xfer & ~full;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                // start_i is deliberately not looked at here.
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    if (word_last_i) begin
                        state_d = (sum_q == word_in_i) ? S_HOLD : S_ERROR;
                    end else if (full) begin
                        state_d = S_ERROR;
                    end
`else
                    if (full) begin
                        state_d = S_ERROR;
                    end else if (word_last_i) begin
                        state_d = S_HOLD;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_C) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_i) state_d = S_LOAD;
            end
            S_ERROR: begin
                if (start_i) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values. Every output is a register loaded from
    // the next state, so status flags change in the same cycle as the state.
    // -------------------------------------------------------------------------
    assign entering_load = (state_d == S_LOAD) && (state_q != S_LOAD);
    assign entering_hold = (state_d == S_HOLD) && (state_q != S_HOLD);

    always_comb begin
        word_ready_d = (state_d == S_LOAD);
        pc_reset_d   = (state_d != S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_HOLD);
        done_d       = (state_d == S_RUN);
        error_d      = (state_d == S_ERROR);

        load_d  = do_write;
        instr_d = instr_q;
        addr_d  = addr_q;
        if (do_write) begin
            instr_d = word_in_i;
            addr_d  = count_q[ADDR_W-1:0];
        end

        // The count doubles as the write address. It stops at DEPTH_C
        // because writes are suppressed once full.
        count_d = count_q;
        if (entering_load) begin
            count_d = '0;
        end else if (do_write) begin
            count_d = count_q + CW'(1);
        end

        // Saturate the visible count if the memory fills the whole address
        // space and the value no longer fits in ADDR_W bits.
        word_count_d = count_d[ADDR_W] ? {ADDR_W{1'b1}} : count_d[ADDR_W-1:0];

        // The first HOLD cycle is the final write cycle, counted as 1. The
        // release therefore lands RESET_HOLD cycles after that write.
        hold_d = hold_q;
        if (entering_hold) begin
            hold_d = 8'd1;
        end else if ((state_q == S_HOLD) && (hold_q != HOLD_C)) begin
            hold_d = hold_q + 8'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        sum_d = sum_q;
        if (entering_load) begin
            sum_d = 16'h0000;
        end else if (do_write) begin
            sum_d = sum_q + word_in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_ready_q <= 1'b0;
            pc_reset_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_q       <= 1'b0;
            instr_q      <= 16'h0000;
            addr_q       <= '0;
            count_q      <= '0;
            word_count_q <= '0;
            hold_q       <= 8'd0;
        end else begin
            word_ready_q <= word_ready_d;
            pc_reset_q   <= pc_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            load_q       <= load_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            word_count_q <= word_count_d;
            hold_q       <= hold_d;
        end
    end

    assign word_ready_o       = word_ready_q;
    assign instruction_in_o   = instr_q;
    assign load_address_o     = addr_q;
    assign load_instruction_o = load_q;
    assign pc_reset_o         = pc_reset_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign word_count_o       = word_count_q;
    assign state_o            = state_q;

endmodule
